// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: credit-limited reads into a 2-entry skid buffer.
// Define FIFO_DRAIN_STATS_EN to implement the delivered-word counter (rd_count).
module fifo_drain_ctrl #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  underflow_err,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   occ_e                  occ_q, occ_d;
   logic                  inflight_q;
   logic                  err_q;
   logic [FIFO_WIDTH-1:0] head_q, head_d;
   logic [FIFO_WIDTH-1:0] tail_q, tail_d;
   logic                  pop, push, discard;
   logic [2:0]            credit;

   assign m_valid = (occ_q != EMPTY);
   assign m_data  = head_q;
   assign pop     = m_valid && m_ready;
   assign push    = inflight_q && !fifo_underflow;
   assign discard = inflight_q && fifo_underflow;

   // Words already owned (buffered + in flight) after this cycle's pop.
   assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   assign fifo_rd_en = rst_n && enable && !fifo_empty && (credit < 3'd2);

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case (occ_q)
         EMPTY: begin
            if (push) begin
               head_d = fifo_data_out;
               occ_d  = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_d = fifo_data_out;
            end else if (push) begin
               tail_d = fifo_data_out;
               occ_d  = TWO;
            end else if (pop) begin
               occ_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               head_d = tail_q;
               occ_d  = ONE;
            end
         end
         default: occ_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         head_q     <= head_d;
         tail_q     <= tail_d;
         if (discard) err_q <= 1'b1;
      end
   end

   assign underflow_err = err_q;

`ifdef FIFO_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign rd_count = cnt_q;
`else
   assign rd_count = '0;
`endif

   // The credit limit must keep a landing word from ever meeting a full buffer.
   a_no_push_full: assert property (
      @(posedge clk) disable iff (!rst_n) !(push && occ_q == TWO)
   );

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller for the synchronous FIFO. It drives the FIFO's read port (rd_en), captures data_out one cycle after each read, and presents the words downstream on a valid/ready stream through a 2-entry skid buffer. It sustains one word per cycle while never over-reading, flags FIFO underflow faults, and optionally counts delivered words. It sits between the FIFO's DUT-side outputs and any consumer that applies backpressure.

## Interface
- FIFO_WIDTH, 16, data word width (matches FIFO data_in/data_out)
- CNT_WIDTH, 16, width of delivered-word counter

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = allowed to issue new FIFO reads
- fifo_data_out  in  FIFO_WIDTH  FIFO data_out, valid the cycle after rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag
- fifo_rd_en  out  1  FIFO read enable (combinational)
- m_data  out  FIFO_WIDTH  downstream data (head of buffer)
- m_valid  out  1  downstream data valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- underflow_err  out  1  sticky: FIFO reported underflow on an issued read
- rd_count  out  CNT_WIDTH  words delivered downstream

## Operation
- State = buffer occupancy: EMPTY (0), ONE (1), TWO (2); plus register `inflight` = fifo_rd_en of previous cycle.
- pop = m_valid && m_ready. credit = occ + inflight − pop.
- fifo_rd_en = enable && !fifo_empty && (credit < 2). Combinational on m_ready; never asserted when fifo_empty = 1.
- Capture: when inflight = 1 and fifo_underflow = 0, fifo_data_out is pushed into the buffer tail.
- If inflight = 1 and fifo_underflow = 1: word discarded, not pushed, underflow_err set; stays 1 until reset.
- Transitions: push only → occ+1; pop only → occ−1; push+pop → occ unchanged, head advances to the pushed word if occ was 1. The credit rule guarantees occ never exceeds 2; a push into TWO is a design error (assertion).
- m_valid = (occ != 0); m_data = head entry; m_data holds stable while m_valid && !m_ready.
- enable = 0: no new reads; in-flight and buffered words still deliver normally.
- rd_count increments by 1 on each pop, wraps modulo 2^CNT_WIDTH.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): occ = 0, inflight = 0, m_valid = 0, m_data = 0, underflow_err = 0, rd_count = 0; fifo_rd_en = 0 while rst_n = 0.
- Read latency: fifo_rd_en in cycle N → captured at end of N+1 → m_valid = 1 in cycle N+2.
- Throughput: 1 word/cycle with m_ready held 1 and FIFO non-empty.
- Backpressure: m_ready = 0 → at most 2 further words land (occ reaches 2); fifo_rd_en then 0 until a pop.
- FIFO goes empty mid-burst: rd_en drops same cycle; buffered words drain; no underflow.
- Reset mid-operation: buffered and in-flight words are dropped; no partial output after rst_n rises.

## Configuration
- FIFO_DRAIN_STATS_EN defined: rd_count counter implemented as above.
- Undefined: counter removed, rd_count tied to 0; all other behaviour identical.

## Test plan
- Reset: rst_n = 0 mid-traffic with occ = 2 → next cycle m_valid = 0, fifo_rd_en = 0, rd_count = 0, underflow_err = 0.
- Streaming: FIFO preloaded 0x0001..0x0008, enable = 1, m_ready = 1 → first m_valid 2 cycles after first rd_en, 8 words in order on 8 consecutive cycles, rd_count = 8.
- Backpressure: preload 6 words, m_ready = 0 for 10 cycles → exactly 2 rd_en pulses, m_data = 0x0001 stable; release m_ready → remaining words in order, no loss or duplicate.
- Empty edge: single word 0xABCD written into empty FIFO → one rd_en pulse, m_data = 0xABCD, fifo_rd_en never asserted while fifo_empty = 1.
- Underflow fault: force fifo_underflow = 1 the cycle after a rd_en → word not delivered, underflow_err = 1 and held until reset.
- Enable gating: enable = 0 with 4 words in FIFO → no rd_en; enable = 1 → 4 words delivered; with FIFO_DRAIN_STATS_EN undefined rd_count stays 0.
